mssd_controller: RTL and testbench

- FSM that sequences the multi-port serial-to-demux datapath.
- Detects a start bit on SerIn, then drives shift/count enables to capture a 2-bit port number and a 4-bit data length.
- Loads the transfer counter, then holds the transfer phase while SerIn is routed to the selected port.
- Cross-checks the datapath carry-outs against internal bit counters and flags framing/consistency errors.

---
 rtl/mssd_controller.sv | 170 +++++++++++++++++
 tb/tb_mssd_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mssd_controller.sv
// -----------------------------------------------------------------------------
// mssd_controller
//   Sequencing FSM for the multi-port serial-to-demux datapath.
//   The controller waits for a start bit (SerIn low) and then steps through:
//     PORT  : shifts and counts the port-number field
//     NUM   : shifts and counts the data-length field
//     LOAD  : loads the transfer counter
//     TRANS : routes payload bits until the transfer counter reports zero
//     DONE  : pulses done
//   The datapath counter carries (Co1, Co2) are compared with the controller's
//   own bit counter. If they disagree, the FSM enters ERR and pulses err.
//
// Ports
//   clk     : system clock
//   rst     : synchronous active-high reset, honoured on every clk edge
//   clk_en  : bit-rate enable; state advances only on enabled edges
//   SerIn   : serial line, idle high
//   Co1     : port-number counter carry from the datapath
//   Co2     : data-length counter carry from the datapath
//   CoD     : transfer counter zero flag from the datapath
//   Sh_en   : port-number shift enable
//   cnt1    : port-number counter enable
//   Sh_enD  : data-length shift enable
//   cnt2    : data-length counter enable
//   LdcntD  : transfer counter load
//   cntD    : transfer counter decrement (TRANS and CoD=0)
//   xfer    : current SerIn bit is a payload bit (TRANS and CoD=0)
//   busy    : FSM is not idle
//   done    : one-enabled-cycle pulse at frame end
//   err     : one-enabled-cycle pulse on a consistency error
// -----------------------------------------------------------------------------
module mssd_controller #(
  parameter int PORT_BITS = 2,
  parameter int NUM_BITS  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic SerIn,
  input  logic Co1,
  input  logic Co2,
  input  logic CoD,
  output logic Sh_en,
  output logic cnt1,
  output logic Sh_enD,
  output logic cnt2,
  output logic LdcntD,
  output logic cntD,
  output logic xfer,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAXB = (PORT_BITS > NUM_BITS) ? PORT_BITS : NUM_BITS;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [BW-1:0] PORT_LAST = BW'(PORT_BITS - 1);
  localparam logic [BW-1:0] NUM_LAST  = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PORT,
    S_NUM,
    S_LOAD,
    S_TRANS,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_next;

  // Registered Moore outputs. They are loaded together with the state, so
  // each one always matches the state that is currently held.
  logic r_sh_en;
  logic r_sh_end;
  logic r_ldcntd;
  logic r_trans;
  logic r_busy;
  logic r_done;
  logic r_err;

  // Next-state logic. The field checks compare the datapath carry with the
  // internal bit counter. A carry seen too early is an error. A carry that
  // is missing on the last bit is also an error.
  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        if (!SerIn) begin
          w_state_next = S_PORT;
          w_bcnt_next  = '0;
        end
      end
      S_PORT: begin
        if (Co1 && (r_bcnt == PORT_LAST)) begin
          w_state_next = S_NUM;
          w_bcnt_next  = '0;
        end else if (Co1 || (r_bcnt == PORT_LAST)) begin
          w_state_next = S_ERR;
          w_bcnt_next  = '0;
        end else begin
          w_bcnt_next = r_bcnt + BW'(1);
        end
      end
      S_NUM: begin
        if (Co2 && (r_bcnt == NUM_LAST)) begin
          w_state_next = S_LOAD;
          w_bcnt_next  = '0;
        end else if (Co2 || (r_bcnt == NUM_LAST)) begin
          w_state_next = S_ERR;
          w_bcnt_next  = '0;
        end else begin
          w_bcnt_next = r_bcnt + BW'(1);
        end
      end
      S_LOAD:  w_state_next = S_TRANS;
      S_TRANS: begin
        if (CoD) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: begin
        w_state_next = S_IDLE;
        w_bcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bcnt   <= '0;
      r_sh_en  <= 1'b0;
      r_sh_end <= 1'b0;
      r_ldcntd <= 1'b0;
      r_trans  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (clk_en) begin
      r_state  <= w_state_next;
      r_bcnt   <= w_bcnt_next;
      r_sh_en  <= (w_state_next == S_PORT);
      r_sh_end <= (w_state_next == S_NUM);
      r_ldcntd <= (w_state_next == S_LOAD);
      r_trans  <= (w_state_next == S_TRANS);
      r_busy   <= (w_state_next != S_IDLE);
      r_done   <= (w_state_next == S_DONE);
      r_err    <= (w_state_next == S_ERR);
    end
  end

  assign Sh_en  = r_sh_en;
  assign cnt1   = r_sh_en;
  assign Sh_enD = r_sh_end;
  assign cnt2   = r_sh_end;
  assign LdcntD = r_ldcntd;
  // The decrement is gated by the zero flag. This lets a zero-length
  // transfer leave TRANS without producing any payload bit.
  assign cntD   = r_trans & ~CoD;
  assign xfer   = r_trans & ~CoD;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_mssd_controller.sv
// -----------------------------------------------------------------------------
// tb_mssd_controller
//   Directed testbench for mssd_controller. Each enabled bit period applies one
//   input vector. Just before the enabled edge, the bench compares the packed
//   output vector {Sh_en,cnt1,Sh_enD,cnt2,LdcntD,cntD,xfer,busy,done,err}
//   with a hand-derived constant for the state the FSM should be in.
// -----------------------------------------------------------------------------
module tb_mssd_controller;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic SerIn;
  logic Co1;
  logic Co2;
  logic CoD;
  logic Sh_en;
  logic cnt1;
  logic Sh_enD;
  logic cnt2;
  logic LdcntD;
  logic cntD;
  logic xfer;
  logic busy;
  logic done;
  logic err;

  int total = 0;
  int bad   = 0;

  // Expected output vectors {Sh_en,cnt1,Sh_enD,cnt2,LdcntD,cntD,xfer,busy,done,err}
  localparam logic [9:0] E_IDLE = 10'b00000_00000;
  localparam logic [9:0] E_PORT = 10'b11000_00100;
  localparam logic [9:0] E_NUM  = 10'b00110_00100;
  localparam logic [9:0] E_LOAD = 10'b00001_00100;
  localparam logic [9:0] E_TX   = 10'b00000_11100;
  localparam logic [9:0] E_TZ   = 10'b00000_00100;
  localparam logic [9:0] E_DONE = 10'b00000_00110;
  localparam logic [9:0] E_ERR  = 10'b00000_00101;

  mssd_controller #(.PORT_BITS(2), .NUM_BITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .SerIn  (SerIn),
    .Co1    (Co1),
    .Co2    (Co2),
    .CoD    (CoD),
    .Sh_en  (Sh_en),
    .cnt1   (cnt1),
    .Sh_enD (Sh_enD),
    .cnt2   (cnt2),
    .LdcntD (LdcntD),
    .cntD   (cntD),
    .xfer   (xfer),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {Sh_en, cnt1, Sh_enD, cnt2, LdcntD, cntD, xfer, busy, done, err};
  endfunction

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", tag, got, exp);
    end else begin
      $display("ok   %s outs=%b", tag, got);
    end
  endtask

  // One bit period: inputs are applied at the negedge and outputs are checked.
  // Then a single enabled edge occurs, followed by three disabled clocks.
  // Those three disabled clocks must not move the FSM.
  task automatic step(input string tag, input logic s, input logic c1, input logic c2,
                      input logic cd, input logic [9:0] exp);
    @(negedge clk);
    SerIn = s; Co1 = c1; Co2 = c2; CoD = cd;
    clk_en = 1'b1;
    #1;
    check_val(tag, outs(), exp);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Full frame. hdr holds the six header bits as they appear on SerIn: the
  // port field first, then the length field. Payload bits are random because
  // the controller ignores them. The DONE period presents a low SerIn. That
  // fake start bit must be ignored, so the final period must still be IDLE.
  task automatic frame(input string name, input logic [5:0] hdr, input int len);
    step({name, ":start"}, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step({name, ":port0"}, hdr[5], 1'b0, 1'b0, 1'b0, E_PORT);
    step({name, ":port1"}, hdr[4], 1'b1, 1'b0, 1'b0, E_PORT);
    for (int i = 0; i < 4; i++)
      step($sformatf("%s:num%0d", name, i), hdr[3-i], 1'b0, (i == 3), 1'b0, E_NUM);
    step({name, ":load"}, 1'b1, 1'b0, 1'b0, 1'b0, E_LOAD);
    for (int i = 0; i < len; i++)
      step($sformatf("%s:xfer%0d", name, i), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, E_TX);
    step({name, ":tzero"}, 1'b1, 1'b0, 1'b0, 1'b1, E_TZ);
    step({name, ":done"}, 1'b0, 1'b0, 1'b0, 1'b0, E_DONE);
    step({name, ":idle"}, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; SerIn = 1'b1; Co1 = 1'b0; Co2 = 1'b0; CoD = 1'b0;

    // Reset is applied with clk_en low and must take effect on the first edge.
    @(posedge clk); #1;
    check_val("reset:first_edge", outs(), E_IDLE);
    repeat (2) @(posedge clk); #1;
    check_val("reset:held", outs(), E_IDLE);
    rst = 1'b0;

    // Idle line does not start a frame.
    step("idle:high", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Nominal frame: port 1,0, length 0,0,1,1 (3 payload bits).
    frame("nominal", 6'b10_0011, 3);
    // Zero-length frame.
    frame("zero", 6'b01_0000, 0);
    // Maximum-length frame.
    frame("max", 6'b11_1111, 15);

    // Co1 arrives too early: error on the first PORT cycle.
    step("e1:start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("e1:port0", 1'b1, 1'b1, 1'b0, 1'b0, E_PORT);
    step("e1:err",   1'b1, 1'b0, 1'b0, 1'b0, E_ERR);
    step("e1:idle",  1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Co1 never arrives: error after the last port bit.
    step("e2:start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("e2:port0", 1'b1, 1'b0, 1'b0, 1'b0, E_PORT);
    step("e2:port1", 1'b1, 1'b0, 1'b0, 1'b0, E_PORT);
    step("e2:err",   1'b1, 1'b0, 1'b0, 1'b0, E_ERR);
    step("e2:idle",  1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Co2 never arrives: error after four NUM cycles.
    step("e3:start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("e3:port0", 1'b1, 1'b0, 1'b0, 1'b0, E_PORT);
    step("e3:port1", 1'b1, 1'b1, 1'b0, 1'b0, E_PORT);
    for (int i = 0; i < 4; i++)
      step($sformatf("e3:num%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, E_NUM);
    step("e3:err",   1'b1, 1'b0, 1'b0, 1'b0, E_ERR);
    step("e3:idle",  1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Reset in the middle of TRANS, with clk_en low during the reset clock.
    step("r:start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("r:port0", 1'b1, 1'b0, 1'b0, 1'b0, E_PORT);
    step("r:port1", 1'b1, 1'b1, 1'b0, 1'b0, E_PORT);
    for (int i = 0; i < 4; i++)
      step($sformatf("r:num%0d", i), 1'b1, 1'b0, (i == 3), 1'b0, E_NUM);
    step("r:load", 1'b1, 1'b0, 1'b0, 1'b0, E_LOAD);
    @(negedge clk);
    SerIn = 1'b1; CoD = 1'b0; #1;
    check_val("r:xfer_before_rst", outs(), E_TX);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("r:after_rst", outs(), E_IDLE);
    // Any late done/err pulse would appear on this enabled edge.
    step("r:quiet", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    frame("after_rst", 6'b00_0001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
